// File: rtl/subarashii_pkg.sv
// Shared datapath types for the Subarashii CPU register file, decode and writeback.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: DATA_W, ADDR_W, NUM_REGS, reg_idx_t (register select), word_t (datapath word),
//           reg_array_t (packed view of the whole register file).
package subarashii_pkg;
   localparam int DATA_W   = 16;
   localparam int ADDR_W   = 4;
   localparam int NUM_REGS = 2 ** ADDR_W;

   typedef logic [ADDR_W-1:0]                 reg_idx_t;
   typedef logic [DATA_W-1:0]                 word_t;
   typedef logic [NUM_REGS-1:0][DATA_W-1:0]   reg_array_t;
endpackage

// File: rtl/reg_file_if.sv
// Decode/writeback-facing bundle of the register file: one write port, two read ports.
// Latency: writes land on the next clk edge; reads are combinational.
// Backpressure: none; every request is accepted on the cycle it is presented.
// Signals: wen/selRd/rd (write), selRa/selRb (read selects), ra/rb (read data).
//          master = decode/writeback side, slave = register file.
interface reg_file_if #(
   parameter int DATA_W = subarashii_pkg::DATA_W,
   parameter int ADDR_W = subarashii_pkg::ADDR_W
) ();
   logic              wen;
   logic [ADDR_W-1:0] selRd;
   logic [ADDR_W-1:0] selRa;
   logic [ADDR_W-1:0] selRb;
   logic [DATA_W-1:0] rd;
   logic [DATA_W-1:0] ra;
   logic [DATA_W-1:0] rb;

   modport master (
      output wen, selRd, selRa, selRb, rd,
      input  ra, rb
   );

   modport slave (
      input  wen, selRd, selRa, selRb, rd,
      output ra, rb
   );
endinterface

// File: rtl/reg_file_read_mux.sv
// 2**ADDR_W : 1 word multiplexer used for one register file read port.
// Latency: zero cycles (purely combinational).
// Backpressure: none.
// Ports: regs_i (all registers, packed), sel_i (register index), dat_o (selected word).
module reg_file_read_mux #(
   parameter int DATA_W = subarashii_pkg::DATA_W,
   parameter int ADDR_W = subarashii_pkg::ADDR_W
) (
   input  logic [(2**ADDR_W)-1:0][DATA_W-1:0] regs_i,
   input  logic [ADDR_W-1:0]                  sel_i,
   output logic [DATA_W-1:0]                  dat_o
);
   always_comb begin
      dat_o = regs_i[sel_i];
   end
endmodule

// File: rtl/reg_file.sv
// Sixteen-entry general-purpose register file: one synchronous write port, two combinational read ports.
// Latency: write visible after one clk edge; reads zero cycles, no write-to-read bypass.
// Backpressure: none; writes and reads are accepted every cycle.
// Ports: clk (system clock), rst (synchronous, active-low; clears every register),
//        bus (reg_file_if.slave: wen/selRd/rd write, selRa/selRb -> ra/rb read).
module reg_file
   import subarashii_pkg::*;
#(
   parameter int DATA_W = subarashii_pkg::DATA_W,
   parameter int ADDR_W = subarashii_pkg::ADDR_W
) (
   input  logic      clk,
   input  logic      rst,
   reg_file_if.slave bus
);
   localparam int NREGS = 2 ** ADDR_W;

   logic [NREGS-1:0][DATA_W-1:0] regs_q;
   logic [NREGS-1:0][DATA_W-1:0] regs_d;

   // Next-state: only the selected register changes on a write; reset
   // priority over the write is handled in the flop block below.
   always_comb begin
      regs_d = regs_q;
      if (bus.wen) begin
         regs_d[bus.selRd] = bus.rd;
      end
   end

   // No reset-less initial value: contents are X until the first reset edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         regs_q <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

   // Reads come straight off the flops, so a pending write is not bypassed.
   reg_file_read_mux #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_mux_ra (
      .regs_i (regs_q),
      .sel_i  (bus.selRa),
      .dat_o  (bus.ra)
   );

   reg_file_read_mux #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_mux_rb (
      .regs_i (regs_q),
      .sel_i  (bus.selRb),
      .dat_o  (bus.rb)
   );
endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: stimulus pushes expected ra/rb pairs, a monitor pops and compares.
// Latency: checks sampled 1 ns after each push, well away from the rising clock edge.
// Backpressure: n/a.
module tb_reg_file;
   import subarashii_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   reg_file_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   reg_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      string name;
      word_t ea;
      word_t eb;
   } exp_t;

   exp_t  sb_q[$];
   event  sb_ev;
   int    total = 0;
   int    bad   = 0;
   word_t model [NUM_REGS];

   // Queue an expected (ra, rb) pair for the current selects, then leave the
   // inputs stable long enough for the monitor to sample.
   task automatic push(input string n, input word_t a, input word_t b);
      exp_t e;
      e.name = n;
      e.ea   = a;
      e.eb   = b;
      sb_q.push_back(e);
      -> sb_ev;
      #2;
   endtask

   task automatic drive(input logic w, input reg_idx_t sd, input word_t d,
                        input reg_idx_t sa, input reg_idx_t sb);
      bus.wen   = w;
      bus.selRd = sd;
      bus.rd    = d;
      bus.selRa = sa;
      bus.selRb = sb;
   endtask

   // One clock edge; the reference array follows the same edge, and both read
   // ports are checked against it right after the edge.
   task automatic tick();
      if (!rst) begin
         for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
      end else if (bus.wen) begin
         model[bus.selRd] = bus.rd;
      end
      @(posedge clk);
      #1;
      push("model", model[bus.selRa], model[bus.selRb]);
   endtask

   // Monitor: drains the scoreboard once the DUT outputs have settled.
   initial begin : monitor
      exp_t e;
      forever begin
         @(sb_ev);
         #1;
         while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            total++;
            if (bus.ra !== e.ea || bus.rb !== e.eb) begin
               bad++;
               $display("FAIL %s: selRa=%0d selRb=%0d got ra=%h rb=%h expected ra=%h rb=%h",
                        e.name, bus.selRa, bus.selRb, bus.ra, bus.rb, e.ea, e.eb);
            end
         end
      end
   end

   initial begin : stim
      for (int i = 0; i < NUM_REGS; i++) model[i] = 'x;
      rst = 1'b0;
      drive(1'b0, 4'd0, 16'h0000, 4'd0, 4'd0);
      #1;

      // Reset state
      tick();
      push("reset_state", 16'h0000, 16'h0000);
      rst = 1'b1;

      // Fill every register with 0xFFFF, then reset while a write is requested
      for (int i = 0; i < NUM_REGS; i++) begin
         drive(1'b1, reg_idx_t'(i), 16'hFFFF, reg_idx_t'(i), reg_idx_t'(i));
         tick();
      end
      push("fill_ffff_r15", 16'hFFFF, 16'hFFFF);
      rst = 1'b0;
      drive(1'b1, 4'd9, 16'h1234, 4'd9, 4'd9);
      tick();
      rst = 1'b1;
      for (int i = 0; i < NUM_REGS / 2; i++) begin
         drive(1'b0, 4'd0, 16'h0000, reg_idx_t'(2 * i), reg_idx_t'(2 * i + 1));
         push("reset_clear", 16'h0000, 16'h0000);
      end

      // Sequential fill r0..r14 with their own index
      for (int i = 0; i < 15; i++) begin
         drive(1'b1, reg_idx_t'(i), word_t'(i), reg_idx_t'(i), reg_idx_t'(i));
         push("fill_pre", 16'h0000, 16'h0000);
         tick();
         push("fill_post", word_t'(i), word_t'(i));
      end

      // Write disabled: r3 must keep 3 and 0xBEEF must land nowhere
      drive(1'b0, 4'd3, 16'hBEEF, 4'd3, 4'd3);
      tick();
      push("wen_off_r3", 16'h0003, 16'h0003);
      for (int i = 0; i < NUM_REGS / 2; i++) begin
         drive(1'b0, 4'd3, 16'hBEEF, reg_idx_t'(2 * i), reg_idx_t'(2 * i + 1));
         push("wen_off_scan", word_t'(2 * i), (2 * i + 1 == 15) ? 16'h0000 : word_t'(2 * i + 1));
      end

      // Dual read and combinational select swap
      drive(1'b1, 4'd5, 16'hAAAA, 4'd5, 4'd15);
      tick();
      drive(1'b1, 4'd15, 16'h5555, 4'd5, 4'd15);
      push("dual_pending", 16'hAAAA, 16'h0000);
      tick();
      drive(1'b0, 4'd0, 16'h0000, 4'd5, 4'd15);
      push("dual_read", 16'hAAAA, 16'h5555);
      drive(1'b0, 4'd0, 16'h0000, 4'd15, 4'd5);
      push("dual_swap", 16'h5555, 16'hAAAA);

      // Reset mid-stream with a write pending, then release with the same write
      drive(1'b1, 4'd7, 16'h7777, 4'd7, 4'd5);
      rst = 1'b0;
      tick();
      push("rst_mid", 16'h0000, 16'h0000);
      rst = 1'b1;
      tick();
      push("rst_release_write", 16'h7777, 16'h0000);

      // r0 is ordinary storage: consecutive overwrites
      drive(1'b1, 4'd0, 16'h0001, 4'd0, 4'd0);
      tick();
      push("r0_first", 16'h0001, 16'h0001);
      drive(1'b1, 4'd0, 16'hFFFF, 4'd0, 4'd7);
      push("r0_pending", 16'h0001, 16'h7777);
      tick();
      push("r0_second", 16'hFFFF, 16'h7777);
      drive(1'b0, 4'd0, 16'h0000, 4'd15, 4'd0);
      push("r15_vs_r0", 16'h0000, 16'hFFFF);

      #20;
      if (sb_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: %0d expectations left unchecked, required 0", sb_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
